// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the execute stage.
//   alu_op_e : 4-bit ALU operation code; codes 9..15 behave as PASS
//   FLAG_*   : bit positions inside the {NF, OF, ZF} flag register
//   state_e  : execute-stage sequencer states
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_PASS = 4'd6,
    OP_NOT  = 4'd7,
    OP_MUL  = 4'd8
  } alu_op_e;

  localparam int FLAG_NF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_ZF = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: iterative unsigned shift-add multiplier, one multiplier bit
// per cycle, WIDTH cycles per product.
//   clk, rst_n : clock, async active-low reset
//   start      : load a/b and begin (ignored while abort is high)
//   abort      : drop the current product and go idle
//   a, b       : multiplicand / multiplier (WIDTH bits)
//   done       : high during the last iteration cycle
//   product    : value the product register takes at the end of this cycle;
//                equals a*b when done is high
module exec_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic              run_q, run_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  // {partial sum, remaining multiplier bits}; the multiplier shifts out of the
  // low half while the product shifts in from the top.
  logic [DW-1:0]     acc_q, acc_d;
  logic [WIDTH:0]    sum;
  logic [DW-1:0]     acc_step;

  always_comb begin
    sum      = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[WIDTH-1:1]};
    done     = run_q && (cnt_q == CNT_LAST);
    product  = acc_step;
  end

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d   = 1'b1;
      cnt_d   = '0;
      mcand_d = a;
      acc_d   = {{WIDTH{1'b0}}, b};
    end else if (run_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/exec_stage_seq.sv
// exec_stage_seq: registered execute stage with the EX/MEM buffer absorbed.
// Resolves forwarded/immediate operands, computes single-cycle ALU results,
// runs a WIDTH-cycle multiply, and holds the {NF, OF, ZF} flag register.
//   in_valid/in_ready        : ID/EX handshake; accept = in_valid & in_ready
//   flush                    : kills in-flight work and a same-cycle accept
//   ALU_OP, OPS, IMM, FLG_EN, Fwd_Sel, Data1/2, Immediate_Value, Fwd_Data1/2
//   WB_Address, MR, MW, WB, Stack_PC, Stack_Flags : controls passed through
//   Flags_Load, Flags_Load_Value : flag restore, wins over an ALU flag write
//   out_valid, Data, Address, *_Out, Flags_Out, busy : registered outputs
//
// state | meaning
// IDLE  | accepting; single-cycle ops complete on the accept edge
// MUL   | multiplier iterating, in_ready low; returns to IDLE with the product
module exec_stage_seq
  import exec_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int MUL_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic [3:0]            ALU_OP,
  input  logic                  OPS,
  input  logic                  IMM,
  input  logic                  FLG_EN,
  input  logic [1:0]            Fwd_Sel,
  input  logic [WIDTH-1:0]      Data1,
  input  logic [WIDTH-1:0]      Data2,
  input  logic [WIDTH-1:0]      Immediate_Value,
  input  logic [WIDTH-1:0]      Fwd_Data1,
  input  logic [WIDTH-1:0]      Fwd_Data2,
  input  logic [2:0]            WB_Address,
  input  logic                  MR,
  input  logic                  MW,
  input  logic                  WB,
  input  logic                  Stack_PC,
  input  logic                  Stack_Flags,
  input  logic                  Flags_Load,
  input  logic [2:0]            Flags_Load_Value,
  output logic                  out_valid,
  output logic [2*WIDTH-1:0]    Data,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [2:0]            WB_Address_Out,
  output logic                  MR_Out,
  output logic                  MW_Out,
  output logic                  WB_Out,
  output logic                  Stack_PC_Out,
  output logic                  Stack_Flags_Out,
  output logic [2:0]            Flags_Out,
  output logic                  busy
);

  localparam int DW = 2 * WIDTH;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DW-1:0]         data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            wb_addr_q, wb_addr_d;
  logic                  mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;
  logic                  spc_q, spc_d, sfl_q, sfl_d;
  logic [2:0]            flags_q, flags_d;

  // Controls of an in-flight multiply, released together with its product.
  logic [ADDR_WIDTH-1:0] p_addr_q, p_addr_d;
  logic [2:0]            p_wb_addr_q, p_wb_addr_d;
  logic [4:0]            p_ctl_q, p_ctl_d;
  logic                  p_flg_q, p_flg_d;

  alu_op_e               op;
  logic [WIDTH-1:0]      op1, op2, alu_res;
  logic                  alu_of;
  logic [2:0]            alu_flags, mul_flags;
  logic                  is_mul, take;
  logic                  mul_start, mul_abort, mul_done;
  logic [DW-1:0]         mul_prod;

  always_comb begin
    op  = alu_op_e'(ALU_OP);
    op1 = Fwd_Sel[0] ? Fwd_Data1 : Data1;
    if (OPS)             op2 = WIDTH'(1);
    else if (Fwd_Sel[1]) op2 = Fwd_Data2;
    else if (IMM)        op2 = Immediate_Value;
    else                 op2 = Data2;

    alu_res = op1;
    alu_of  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = op1 + op2;
        alu_of  = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = op1 - op2;
        alu_of  = (op1[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      // Shift amounts of WIDTH or more shift everything out, giving 0.
      OP_SHL:  alu_res = op1 << op2;
      OP_SHR:  alu_res = op1 >> op2;
      OP_NOT:  alu_res = ~op1;
      default: alu_res = op1;
    endcase

    alu_flags          = '0;
    alu_flags[FLAG_NF] = alu_res[WIDTH-1];
    alu_flags[FLAG_OF] = alu_of;
    alu_flags[FLAG_ZF] = (alu_res == '0);

    mul_flags          = '0;
    mul_flags[FLAG_NF] = mul_prod[DW-1];
    mul_flags[FLAG_OF] = |mul_prod[DW-1:WIDTH];
    mul_flags[FLAG_ZF] = (mul_prod == '0);
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL);
  assign is_mul    = (MUL_EN != 0) && (op == OP_MUL);
  assign take      = in_valid && in_ready && !flush;
  assign mul_start = take && is_mul;
  assign mul_abort = flush;

  if (MUL_EN != 0) begin : g_mul
    exec_mul_seq #(
      .WIDTH(WIDTH)
    ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (mul_abort),
      .a       (op1),
      .b       (op2),
      .done    (mul_done),
      .product (mul_prod)
    );
  end else begin : g_no_mul
    assign mul_done = 1'b0;
    assign mul_prod = '0;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    data_d      = data_q;
    addr_d      = addr_q;
    wb_addr_d   = wb_addr_q;
    mr_d        = 1'b0;
    mw_d        = 1'b0;
    wb_d        = 1'b0;
    spc_d       = spc_q;
    sfl_d       = sfl_q;
    flags_d     = flags_q;
    p_addr_d    = p_addr_q;
    p_wb_addr_d = p_wb_addr_q;
    p_ctl_d     = p_ctl_q;
    p_flg_d     = p_flg_q;

    case (state_q)
      IDLE: begin
        if (take) begin
          if (is_mul) begin
            state_d     = MUL;
            p_addr_d    = ADDR_WIDTH'(op1);
            p_wb_addr_d = WB_Address;
            p_ctl_d     = {MR, MW, WB, Stack_PC, Stack_Flags};
            p_flg_d     = FLG_EN;
          end else begin
            out_valid_d = 1'b1;
            data_d      = DW'(alu_res);
            addr_d      = ADDR_WIDTH'(op1);
            wb_addr_d   = WB_Address;
            mr_d        = MR;
            mw_d        = MW;
            wb_d        = WB;
            spc_d       = Stack_PC;
            sfl_d       = Stack_Flags;
            if (FLG_EN) flags_d = alu_flags;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mul_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          data_d      = mul_prod;
          addr_d      = p_addr_q;
          wb_addr_d   = p_wb_addr_q;
          {mr_d, mw_d, wb_d, spc_d, sfl_d} = p_ctl_q;
          if (p_flg_q) flags_d = mul_flags;
        end
      end
      default: state_d = IDLE;
    endcase

    if (Flags_Load) flags_d = Flags_Load_Value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      wb_addr_q   <= '0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      wb_q        <= 1'b0;
      spc_q       <= 1'b0;
      sfl_q       <= 1'b0;
      flags_q     <= '0;
      p_addr_q    <= '0;
      p_wb_addr_q <= '0;
      p_ctl_q     <= '0;
      p_flg_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      wb_addr_q   <= wb_addr_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      wb_q        <= wb_d;
      spc_q       <= spc_d;
      sfl_q       <= sfl_d;
      flags_q     <= flags_d;
      p_addr_q    <= p_addr_d;
      p_wb_addr_q <= p_wb_addr_d;
      p_ctl_q     <= p_ctl_d;
      p_flg_q     <= p_flg_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign Data            = data_q;
  assign Address         = addr_q;
  assign WB_Address_Out  = wb_addr_q;
  assign MR_Out          = mr_q;
  assign MW_Out          = mw_q;
  assign WB_Out          = wb_q;
  assign Stack_PC_Out    = spc_q;
  assign Stack_Flags_Out = sfl_q;
  assign Flags_Out       = flags_q;

endmodule

// File: tb/tb_exec_stage_seq.sv
// Scoreboard bench for exec_stage_seq (WIDTH=16, ADDR_WIDTH=32, MUL_EN=1).
// Stimulus pushes the predicted response on accept; an independent monitor
// pops and compares whenever out_valid is seen.
module tb_exec_stage_seq;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] d1, d2, imm, f1, f2;
    logic [1:0]  fsel;
    logic        ops, imm_sel, flg;
    logic [2:0]  wba;
    logic [4:0]  ctl;   // {MR, MW, WB, Stack_PC, Stack_Flags}
    logic        fl_load;
    logic [2:0]  fl_val;
  } instr_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  wba;
    logic [4:0]  ctl;
    logic [2:0]  flags;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush;
  logic [3:0]  ALU_OP;
  logic        OPS, IMM, FLG_EN;
  logic [1:0]  Fwd_Sel;
  logic [15:0] Data1, Data2, Immediate_Value, Fwd_Data1, Fwd_Data2;
  logic [2:0]  WB_Address;
  logic        MR, MW, WB, Stack_PC, Stack_Flags;
  logic        Flags_Load;
  logic [2:0]  Flags_Load_Value;
  logic        out_valid;
  logic [31:0] Data;
  logic [31:0] Address;
  logic [2:0]  WB_Address_Out;
  logic        MR_Out, MW_Out, WB_Out, Stack_PC_Out, Stack_Flags_Out;
  logic [2:0]  Flags_Out;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [2:0] mflags;

  exec_stage_seq #(.WIDTH(16), .ADDR_WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .ALU_OP(ALU_OP), .OPS(OPS), .IMM(IMM), .FLG_EN(FLG_EN),
    .Fwd_Sel(Fwd_Sel), .Data1(Data1), .Data2(Data2),
    .Immediate_Value(Immediate_Value), .Fwd_Data1(Fwd_Data1),
    .Fwd_Data2(Fwd_Data2), .WB_Address(WB_Address), .MR(MR), .MW(MW),
    .WB(WB), .Stack_PC(Stack_PC), .Stack_Flags(Stack_Flags),
    .Flags_Load(Flags_Load), .Flags_Load_Value(Flags_Load_Value),
    .out_valid(out_valid), .Data(Data), .Address(Address),
    .WB_Address_Out(WB_Address_Out), .MR_Out(MR_Out), .MW_Out(MW_Out),
    .WB_Out(WB_Out), .Stack_PC_Out(Stack_PC_Out),
    .Stack_Flags_Out(Stack_Flags_Out), .Flags_Out(Flags_Out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the selected operands.
  function automatic exp_t predict(input instr_t i, input logic [2:0] fl_in);
    exp_t e;
    logic [15:0] o1, o2;
    longint a, b, sa, sb, r, s;
    logic nf, of, zf;
    o1 = i.fsel[0] ? i.f1 : i.d1;
    if (i.ops)          o2 = 16'd1;
    else if (i.fsel[1]) o2 = i.f2;
    else if (i.imm_sel) o2 = i.imm;
    else                o2 = i.d2;
    a = o1; b = o2; sa = $signed(o1); sb = $signed(o2);
    of = 1'b0;
    case (i.op)
      4'd0: begin r = (a + b) % 65536; s = sa + sb; of = (s > 32767) || (s < -32768); end
      4'd1: begin r = (a - b + 65536) % 65536; s = sa - sb; of = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (b >= 16) ? 0 : (a << b) % 65536;
      4'd5: r = (b >= 16) ? 0 : (a >> b);
      4'd7: r = 65535 - a;
      4'd8: begin r = a * b; of = (r > 65535); end
      default: r = a;
    endcase
    nf = (i.op == 4'd8) ? r[31] : r[15];
    zf = (r == 0);
    e.data = r[31:0];
    e.addr = {16'h0000, o1};
    e.wba  = i.wba;
    e.ctl  = i.ctl;
    if (i.fl_load)  e.flags = i.fl_val;
    else if (i.flg) e.flags = {nf, of, zf};
    else            e.flags = fl_in;
    return e;
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [15:0] d1, input logic [15:0] d2);
    instr_t i;
    i.op = op; i.d1 = d1; i.d2 = d2; i.imm = 16'h0; i.f1 = 16'h0; i.f2 = 16'h0;
    i.fsel = 2'b00; i.ops = 1'b0; i.imm_sel = 1'b0; i.flg = 1'b1;
    i.wba = 3'd5; i.ctl = 5'b10110; i.fl_load = 1'b0; i.fl_val = 3'b000;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.op = ($urandom_range(0, 4) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
    i.d1 = 16'($urandom);
    i.d2 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    i.imm = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
    i.f1 = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
    i.f2 = 16'($urandom);
    i.fsel = 2'($urandom);
    i.ops = ($urandom_range(0, 5) == 0);
    i.imm_sel = 1'($urandom);
    i.flg = 1'($urandom);
    i.wba = 3'($urandom);
    i.ctl = 5'($urandom);
    i.fl_load = 1'b0;
    i.fl_val = 3'b000;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ALU_OP = i.op; Data1 = i.d1; Data2 = i.d2; Immediate_Value = i.imm;
    Fwd_Data1 = i.f1; Fwd_Data2 = i.f2; Fwd_Sel = i.fsel; OPS = i.ops;
    IMM = i.imm_sel; FLG_EN = i.flg; WB_Address = i.wba;
    {MR, MW, WB, Stack_PC, Stack_Flags} = i.ctl;
    Flags_Load = i.fl_load; Flags_Load_Value = i.fl_val;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input instr_t i, input bit push);
    int waitc;
    exp_t e;
    drive(i);
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      Flags_Load = 1'b0;
      return;
    end
    if (push) begin
      e = predict(i, mflags);
      exp_q.push_back(e);
      mflags = e.flags;
    end
    @(negedge clk);
    in_valid = 1'b0;
    Flags_Load = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: out_valid=1 with Data %0h, required no output", Data);
        end else begin
          e = exp_q.pop_front();
          chk("data", 64'(Data), 64'(e.data));
          chk("address", 64'(Address), 64'(e.addr));
          chk("controls", 64'({WB_Address_Out, MR_Out, MW_Out, WB_Out, Stack_PC_Out, Stack_Flags_Out}),
              64'({e.wba, e.ctl}));
          chk("flags", 64'(Flags_Out), 64'(e.flags));
        end
      end else begin
        chk("mem_ctl_idle", 64'({MR_Out, MW_Out, WB_Out}), 64'(0));
      end
    end
  end

  initial begin
    instr_t i;
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    drive(mk(4'd0, 16'h0, 16'h0));
    Flags_Load = 1'b0;
    mflags = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({Data, Address}), 64'(0));
    chk("rst_ctl_flags", 64'({WB_Address_Out, MR_Out, MW_Out, WB_Out, Stack_PC_Out, Stack_Flags_Out, Flags_Out, busy}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed arithmetic cases
    issue(mk(4'd0, 16'h7FFF, 16'h0001), 1);
    i = mk(4'd1, 16'h0005, 16'h1234); i.imm_sel = 1'b1; i.imm = 16'h0005;
    issue(i, 1);
    i.fsel = 2'b10; i.f2 = 16'h0004;
    issue(i, 1);

    i = mk(4'd8, 16'h00FF, 16'h0101);
    issue(i, 1);
    cnt = 1;
    while (!in_ready && cnt < 100) begin @(negedge clk); cnt++; end
    chk("mul_ready_low_cycles", 64'(cnt - 1), 64'(16));
    chk("mul_out_valid_on_ready", 64'(out_valid), 64'(1));
    issue(mk(4'd8, 16'hFFFF, 16'hFFFF), 1);

    issue(mk(4'd4, 16'h1234, 16'd16), 1);
    i = mk(4'd0, 16'hFFFF, 16'h5555); i.ops = 1'b1;
    issue(i, 1);
    issue(mk(4'd5, 16'h8000, 16'd15), 1);
    issue(mk(4'd7, 16'h00F0, 16'h0), 1);
    repeat (2) @(negedge clk);

    // Flush in the middle of a multiply
    issue(mk(4'd8, 16'h1234, 16'h0F0F), 0);
    repeat (3) @(negedge clk);
    chk("mul_busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_flags_kept", 64'(Flags_Out), 64'(mflags));
    repeat (20) @(negedge clk);

    // Accept in the same cycle as flush is dropped
    drive(mk(4'd3, 16'h00F0, 16'h0F00));
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_dropped", 64'(out_valid), 64'(0));
    chk("flush_accept_flags", 64'(Flags_Out), 64'(mflags));

    // Flags_Load alongside an ALU flag write, then reset during a multiply
    i = mk(4'd0, 16'h7FFF, 16'h0001); i.fl_load = 1'b1; i.fl_val = 3'b011;
    issue(i, 1);
    issue(mk(4'd8, 16'hFFFF, 16'hFFFF), 0);
    repeat (4) @(negedge clk);
    chk("flags_load_wins", 64'(Flags_Out), 64'(3'b011));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mul_outputs", 64'({Data, Address}), 64'(0));
    chk("rst_mid_mul_state", 64'({out_valid, busy, Flags_Out, MR_Out, MW_Out, WB_Out, Stack_PC_Out, Stack_Flags_Out, WB_Address_Out}), 64'(0));
    mflags = 3'b000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'({in_ready, busy}), 64'(2'b10));
    repeat (25) @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      issue(rand_instr(), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
